// File: rtl/macro_alu_array.sv
// NLANES x WIDTH-bit ALU behind a two-stage valid/ready pipeline with a
// consumed-result counter. Define MACRO_ALU_SAT_EN for saturating ADD/SUB.
module macro_alu_array #(
   parameter int WIDTH  = 4,
   parameter int NLANES = 2,
   parameter int CNTW   = 8
) (
   input  logic                        clock,
   input  logic                        resetb,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NLANES*WIDTH-1:0]     in_a,
   input  logic [NLANES*WIDTH-1:0]     in_b,
   input  logic [NLANES*2-1:0]         in_sel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NLANES*(WIDTH+1)-1:0] out_res,
   output logic [NLANES-1:0]           out_zero,
   output logic [CNTW-1:0]             out_count
);

   localparam int RW = WIDTH + 1;

   logic                    s1_valid_q;
   logic [NLANES*WIDTH-1:0] a_q, b_q;
   logic [NLANES*2-1:0]     sel_q;
   logic                    out_valid_q;
   logic [NLANES*RW-1:0]    res_q, res_d;
   logic [NLANES-1:0]       zero_q, zero_d;
   logic [CNTW-1:0]         cnt_q;

   logic                    s2_load;
   logic                    accept;
   logic                    consume;

   logic [WIDTH-1:0]        la, lb;
   logic [1:0]              lsel;
   logic [RW-1:0]           lr;

   assign consume  = out_valid_q & out_ready;
   assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s2_load;
   assign accept   = in_valid & in_ready;

   always_comb begin
      res_d  = '0;
      zero_d = '0;
      la     = '0;
      lb     = '0;
      lsel   = '0;
      lr     = '0;
      for (int i = 0; i < NLANES; i++) begin
         la   = a_q[i*WIDTH +: WIDTH];
         lb   = b_q[i*WIDTH +: WIDTH];
         lsel = sel_q[i*2 +: 2];
         case (lsel)
            2'b00: begin
               lr = {1'b0, la} + {1'b0, lb};
`ifdef MACRO_ALU_SAT_EN
               if (lr[WIDTH]) lr = {1'b0, {WIDTH{1'b1}}};
`endif
            end
            2'b01: begin
               // the extra bit of the difference is the borrow
               lr = {1'b0, la} - {1'b0, lb};
`ifdef MACRO_ALU_SAT_EN
               if (lr[WIDTH]) lr = '0;
`endif
            end
            2'b10:   lr = {1'b0, la & lb};
            default: lr = {1'b0, la | lb};
         endcase
         res_d[i*RW +: RW] = lr;
         zero_d[i]         = (lr[WIDTH-1:0] == '0);
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= '0;
         cnt_q       <= '0;
      end else begin
         if (accept) begin
            s1_valid_q <= 1'b1;
            a_q        <= in_a;
            b_q        <= in_b;
            sel_q      <= in_sel;
         end else if (s2_load) begin
            s1_valid_q <= 1'b0;
         end
         if (s2_load) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            zero_q      <= zero_d;
         end else if (consume) begin
            out_valid_q <= 1'b0;
         end
         if (consume) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_res   = res_q;
   assign out_zero  = zero_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_macro_alu_array.sv
// Scoreboard bench for macro_alu_array (WIDTH=4, NLANES=2, CNTW=4).
// Expected bundles are queued on accept and compared on consume.
module tb_macro_alu_array;

   logic       clock;
   logic       resetb;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_sel;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_res;
   logic [1:0] out_zero;
   logic [3:0] out_count;

   int checks;
   int failures;
   int exp_cnt;
   logic [11:0] sb_q[$];

   macro_alu_array #(.WIDTH(4), .NLANES(2), .CNTW(4)) dut (
      .clock(clock), .resetb(resetb),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_zero(out_zero), .out_count(out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] mdl(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] s);
      int x;
      logic [4:0] r;
      r = '0;
      case (s)
         2'd0: begin
            x = int'(a) + int'(b);
`ifdef MACRO_ALU_SAT_EN
            if (x > 15) x = 15;
`endif
            r = x[4:0];
         end
         2'd1: begin
            x = int'(a) - int'(b);
`ifdef MACRO_ALU_SAT_EN
            if (x < 0) x = 0;
`else
            if (x < 0) x = x + 32;
`endif
            r = x[4:0];
         end
         2'd2: r = {1'b0, a & b};
         default: r = {1'b0, a | b};
      endcase
      return r;
   endfunction

   function automatic logic [11:0] mdl_bundle(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [3:0] s);
      logic [4:0] r0, r1;
      r0 = mdl(a[3:0], b[3:0], s[1:0]);
      r1 = mdl(a[7:4], b[7:4], s[3:2]);
      return {r1, r0, r1[3:0] == 4'd0, r0[3:0] == 4'd0};
   endfunction

   always @(negedge clock) begin
      if (!resetb) begin
         sb_q.delete();
         exp_cnt = 0;
      end else if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("stale", {31'd0, out_valid}, 32'd0);
         end else begin
            logic [11:0] e;
            e = sb_q.pop_front();
            check("res", {22'd0, out_res}, {22'd0, e[11:2]});
            check("zero", {30'd0, out_zero}, {30'd0, e[1:0]});
            check("cnt", {28'd0, out_count}, exp_cnt % 16);
            exp_cnt++;
         end
      end
   end

   task automatic send_exp(input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input logic [11:0] e,
                           input bit rnd);
      bit got;
      got = 1'b0;
      in_a = a;
      in_b = b;
      in_sel = s;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         if (in_ready) got = 1'b1;
         @(posedge clock);
         if (got) sb_q.push_back(e);
         #1;
      end
      in_valid = 1'b0;
      if (!got) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, input bit rnd);
      send_exp(a, b, s, mdl_bundle(a, b, s), rnd);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clock);
         #1;
         if (sb_q.size() == 0 && !out_valid) done = 1'b1;
      end
      check("drain", {31'd0, done}, 32'd1);
   endtask

   task automatic do_reset();
      #1;
      resetb = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetb = 1'b1;
      @(posedge clock);
      #1;
   endtask

   localparam logic [11:0] E_ADD =
`ifdef MACRO_ALU_SAT_EN
      {5'b00000, 5'b01111, 2'b10};
`else
      {5'b00000, 5'b10010, 2'b10};
`endif
   localparam logic [11:0] E_SUBAND =
`ifdef MACRO_ALU_SAT_EN
      {5'b00000, 5'b00000, 2'b11};
`else
      {5'b00000, 5'b11110, 2'b10};
`endif
   localparam logic [11:0] E_OR = {5'b01111, 5'b01111, 2'b00};

   initial begin
      checks = 0;
      failures = 0;
      exp_cnt = 0;
      resetb = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_sel = '0;
      out_ready = 1'b0;
      #12;
      resetb = 1'b1;
      @(posedge clock);
      #1;
      check("rst_ovalid", {31'd0, out_valid}, 32'd0);
      check("rst_irdy", {31'd0, in_ready}, 32'd1);
      check("rst_cnt", {28'd0, out_count}, 32'd0);
      check("rst_res", {22'd0, out_res}, 32'd0);
      check("rst_zero", {30'd0, out_zero}, 32'd0);

      // basic ADD with latency check
      out_ready = 1'b1;
      in_a = 8'h09;
      in_b = 8'h09;
      in_sel = 4'b0000;
      in_valid = 1'b1;
      @(posedge clock);
      sb_q.push_back(E_ADD);
      #1;
      in_valid = 1'b0;
      check("lat_edge1", {31'd0, out_valid}, 32'd0);
      @(posedge clock);
      #1;
      check("lat_edge2", {31'd0, out_valid}, 32'd1);

      send_exp(8'hC3, 8'h35, 4'b1001, E_SUBAND, 1'b0);
      send_exp(8'hCF, 8'h30, 4'b1111, E_OR, 1'b0);
      drain();

      // backpressure: two held, third stalls until release
      do_reset();
      out_ready = 1'b0;
      send(8'h12, 8'h34, 4'b0000, 1'b0);
      send(8'h56, 8'h78, 4'b0101, 1'b0);
      in_a = 8'h9A;
      in_b = 8'hBC;
      in_sel = 4'b1110;
      in_valid = 1'b1;
      @(negedge clock);
      check("bp_full", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
      check("bp_full2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clock);
      sb_q.push_back(mdl_bundle(8'h9A, 8'hBC, 4'b1110));
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      check("bp_cnt", {28'd0, out_count}, 32'd3);
      check("bp_empty", {31'd0, out_valid}, 32'd0);
      check("bp_sb", sb_q.size(), 32'd0);

      // counter wrap
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++)
         send(8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
      drain();
      check("wrap16", {28'd0, out_count}, 32'd0);
      send(8'h11, 8'h22, 4'b0011, 1'b0);
      drain();
      check("wrap17", {28'd0, out_count}, 32'd1);

      // reset with two bundles held
      out_ready = 1'b0;
      send(8'h33, 8'h44, 4'b0000, 1'b0);
      send(8'h55, 8'h66, 4'b1010, 1'b0);
      @(posedge clock);
      #3;
      resetb = 1'b0;
      #1;
      check("mid_rst_ovalid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_cnt", {28'd0, out_count}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      resetb = 1'b1;
      @(posedge clock);
      #1;
      check("mid_rel_irdy", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) @(posedge clock);
      #1;
      check("mid_no_stale", {31'd0, out_valid}, 32'd0);
      check("mid_cnt", {28'd0, out_count}, 32'd0);

      // random traffic with random backpressure
      for (int i = 0; i < 40; i++)
         send(8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
      drain();
      check("rand_cnt", {28'd0, out_count}, 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
